// File: rtl/fetch_pkg.sv
// Shared types, constants and the text-segment range check for instruction fetch.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;

    // True when addr lies in [base, base + 4*depth). The subtraction wraps for
    // addresses below base, so the lower bound is checked explicitly.
    function automatic logic in_text(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < 32'(depth * 4));
    endfunction

endpackage

// File: rtl/fetch_controller_pc_register.sv
// Program counter flop: load has priority over increment, otherwise hold.
module pc_register #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  incr_i,
    input  logic [DATA_WIDTH-1:0] load_val_i,
    output logic [DATA_WIDTH-1:0] pc_o
);

    logic [DATA_WIDTH-1:0] pc_q;

    // PC update; increment wraps modulo 2^DATA_WIDTH, the range check catches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pc_q <= RESET_VAL;
        else if (load_i) pc_q <= load_val_i;
        else if (incr_i) pc_q <= pc_q + DATA_WIDTH'(4);
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, addresses the program ROM and
// registers the returned word into the IF/ID boundary.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(DEFAULT_TEXT_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic [DATA_WIDTH-1:0] pm_instruction,
    output logic [DATA_WIDTH-1:0] pm_address,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic [DATA_WIDTH-1:0] if_instruction,
    output logic                  if_valid,
    output logic                  fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [DATA_WIDTH-1:0] if_pc4_q, if_pc4_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic                  if_valid_q, if_valid_d;
    logic                  pc_load, pc_incr;
    logic                  tgt_ok, pc_ok;

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VAL  (TEXT_BASE)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .incr_i     (pc_incr),
        .load_val_i (redirect_target),
        .pc_o       (pc)
    );

    assign pm_address = pc - TEXT_BASE;
    assign tgt_ok     = (redirect_target[1:0] == 2'b00) &&
                        in_text(32'(redirect_target), 32'(TEXT_BASE), MEMORY_DEPTH);
    assign pc_ok      = in_text(32'(pc), 32'(TEXT_BASE), MEMORY_DEPTH);

    // Next-state and IF/ID next values; redirect beats stall so a taken branch
    // still squashes the wrong-path instruction while the pipe is held.
    always_comb begin
        state_d    = state_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if_valid_d = 1'b0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    // A bad target is still loaded so the frozen PC names the
                    // offending address.
                    pc_load    = 1'b1;
                    if (tgt_ok) if_instr_d = DATA_WIDTH'(NOP);
                    else        state_d    = FAULT;
                end else if (stall) begin
                    // hold PC and IF/ID
                end else if (!enable) begin
                    state_d    = IDLE;
                    if_valid_d = 1'b0;
                end else if (!pc_ok) begin
                    state_d    = FAULT;
                    if_valid_d = 1'b0;
                end else begin
                    if_instr_d = pm_instruction;
                    if_pc_d    = pc;
                    if_pc4_d   = pc + DATA_WIDTH'(4);
                    if_valid_d = 1'b1;
                    pc_incr    = 1'b1;
                end
            end
            FAULT: begin
                if_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and IF/ID boundary registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            if_pc_q    <= TEXT_BASE;
            if_pc4_q   <= TEXT_BASE + DATA_WIDTH'(4);
            if_instr_q <= DATA_WIDTH'(NOP);
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc4_q;
    assign if_instruction = if_instr_q;
    assign if_valid       = if_valid_q;
    assign fetch_fault    = (state_q == FAULT);

endmodule
